// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet constants, parser FSM states and a byte-wise reflected CRC-32 step.
package eth_pkg;
   localparam int          ETH_HDR_LEN   = 14;
   localparam int          ETH_FCS_LEN   = 4;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
   localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DROP} eth_state_e;
   // One byte through the LSB-first CRC-32 shift register, no final inversion.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
      return r;
   endfunction
endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: running reflected CRC-32, one byte per cycle.
//   clk, rst_n : clock, async active-low reset
//   clear      : reload CRC32_INIT (wins over en)
//   en, data   : fold data into the register
//   crc        : current register value
module eth_crc32
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);
   logic [31:0] crc_q, crc_d;
   always_comb crc_d = clear ? CRC32_INIT : en ? crc32_byte(crc_q, data) : crc_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) crc_q <= CRC32_INIT;
      else        crc_q <= crc_d;
   assign crc = crc_q;
endmodule

// File: rtl/eth_rx_parser.sv
// eth_rx_parser: streaming Ethernet receiver; captures header, forwards payload minus FCS,
// checks CRC-32/length and emits a per-frame status pulse.
//   in_*   : MAC/PHY byte stream (valid/ready, in_last on final FCS byte)
//   out_*  : payload stream (valid/ready, out_last with out_err)
//   stat_* : status word, stat_valid pulses one cycle after in_last is accepted
// Optional: `define ETH_RX_DST_FILTER_EN drops frames not addressed to LOCAL_MAC or broadcast.
module eth_rx_parser
   import eth_pkg::*;
#(
   parameter int          MIN_FRAME = 64,
   parameter int          MAX_FRAME = 1518,
   parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_last,
   output logic        out_err,
   input  logic        out_ready,
   output logic        stat_valid,
   output logic [15:0] stat_len,
   output logic [15:0] stat_ethertype,
   output logic [47:0] stat_dst_mac,
   output logic [47:0] stat_src_mac,
   output logic        stat_crc_err,
   output logic        stat_runt,
   output logic        stat_giant,
   output logic        stat_filtered
);
`ifdef ETH_RX_DST_FILTER_EN
   localparam logic FILT_EN = 1'b1;
`else
   localparam logic FILT_EN = 1'b0;
`endif
   eth_state_e  state_q, state_d;
   logic [15:0] count_q, count_d, len_next;
   logic [31:0] dly_q, dly_d, crc, crc_next;
   logic [47:0] dst_q, dst_d, src_q, src_d;
   logic [15:0] type_q, type_d;
   logic        giant_q, giant_d, filt_q, filt_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d, out_last_q, out_last_d, out_err_q, out_err_d;
   logic        stat_valid_q, stat_valid_d;
   logic [15:0] stat_len_q, stat_len_d, stat_type_q, stat_type_d;
   logic [47:0] stat_dst_q, stat_dst_d, stat_src_q, stat_src_d;
   logic        stat_crc_q, stat_crc_d, stat_runt_q, stat_runt_d;
   logic        stat_giant_q, stat_giant_d, stat_filt_q, stat_filt_d;
   logic        accept, fin, giant_now, filt_now, emit, crc_err, runt;

   assign in_ready = !out_valid_q || out_ready;

   eth_crc32 u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (fin),
      .en    (accept),
      .data  (in_data),
      .crc   (crc)
   );

   always_comb begin
      accept    = in_valid && in_ready;
      fin       = accept && in_last;
      len_next  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      crc_next  = crc32_byte(crc, in_data);
      crc_err   = crc_next != CRC32_RESIDUE;
      runt      = count_q < 16'(MIN_FRAME - 1);
      giant_now = count_q == 16'(MAX_FRAME);
      // Header fields shift in MSB-first; the in-flight byte is folded in so status sees it too.
      dst_d     = (accept && count_q < 16'd6) ? {dst_q[39:0], in_data} : dst_q;
      src_d     = (accept && count_q >= 16'd6 && count_q < 16'd12) ? {src_q[39:0], in_data} : src_q;
      type_d    = (accept && count_q >= 16'd12 && count_q < 16'(ETH_HDR_LEN)) ? {type_q[7:0], in_data} : type_q;
      filt_now  = FILT_EN && state_q == ST_HDR && count_q == 16'd5
                  && dst_d != LOCAL_MAC && dst_d != ETH_BCAST_MAC;
      // Byte k-4 leaves the delay line; only header-free bytes in PAYLOAD are forwarded.
      emit      = accept && state_q == ST_PAYLOAD && count_q >= 16'(ETH_HDR_LEN + ETH_FCS_LEN);
      state_d   = !accept ? state_q : in_last ? ST_IDLE :
                  (state_q == ST_IDLE) ? ST_HDR :
                  (state_q == ST_HDR) ? (filt_now ? ST_DROP :
                                         (count_q == 16'(ETH_HDR_LEN - 1)) ? ST_PAYLOAD : ST_HDR) :
                  (state_q == ST_PAYLOAD && giant_now) ? ST_DROP : state_q;
      count_d   = !accept ? count_q : in_last ? 16'd0 : len_next;
      dly_d     = !accept ? dly_q : in_last ? 32'd0 : {dly_q[23:0], in_data};
      giant_d   = !accept ? giant_q : !in_last && (giant_q || giant_now);
      filt_d    = !accept ? filt_q : !in_last && (filt_q || filt_now);
      out_valid_d = emit || (out_valid_q && !out_ready);
      out_data_d  = emit ? dly_q[31:24] : out_data_q;
      out_last_d  = emit ? (in_last || giant_now) : out_last_q && out_valid_d;
      out_err_d   = emit ? (giant_now || (in_last && (crc_err || runt))) : out_err_q && out_valid_d;
      stat_valid_d = fin;
      stat_len_d   = fin ? len_next : stat_len_q;
      stat_type_d  = fin ? type_d : stat_type_q;
      stat_dst_d   = fin ? dst_d : stat_dst_q;
      stat_src_d   = fin ? src_d : stat_src_q;
      stat_crc_d   = fin ? crc_err : stat_crc_q;
      stat_runt_d  = fin ? runt : stat_runt_q;
      stat_giant_d = fin ? (giant_q || giant_now) : stat_giant_q;
      stat_filt_d  = fin ? (filt_q || filt_now) : stat_filt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         dly_q        <= '0;
         dst_q        <= '0;
         src_q        <= '0;
         type_q       <= '0;
         giant_q      <= 1'b0;
         filt_q       <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_err_q    <= 1'b0;
         stat_valid_q <= 1'b0;
         stat_len_q   <= '0;
         stat_type_q  <= '0;
         stat_dst_q   <= '0;
         stat_src_q   <= '0;
         stat_crc_q   <= 1'b0;
         stat_runt_q  <= 1'b0;
         stat_giant_q <= 1'b0;
         stat_filt_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         dly_q        <= dly_d;
         dst_q        <= dst_d;
         src_q        <= src_d;
         type_q       <= type_d;
         giant_q      <= giant_d;
         filt_q       <= filt_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_err_q    <= out_err_d;
         stat_valid_q <= stat_valid_d;
         stat_len_q   <= stat_len_d;
         stat_type_q  <= stat_type_d;
         stat_dst_q   <= stat_dst_d;
         stat_src_q   <= stat_src_d;
         stat_crc_q   <= stat_crc_d;
         stat_runt_q  <= stat_runt_d;
         stat_giant_q <= stat_giant_d;
         stat_filt_q  <= stat_filt_d;
      end
   end

   assign out_data       = out_data_q;
   assign out_valid      = out_valid_q;
   assign out_last       = out_last_q;
   assign out_err        = out_err_q;
   assign stat_valid     = stat_valid_q;
   assign stat_len       = stat_len_q;
   assign stat_ethertype = stat_type_q;
   assign stat_dst_mac   = stat_dst_q;
   assign stat_src_mac   = stat_src_q;
   assign stat_crc_err   = stat_crc_q;
   assign stat_runt      = stat_runt_q;
   assign stat_giant     = stat_giant_q;
   assign stat_filtered  = stat_filt_q;
endmodule

// File: tb/tb_eth_rx_parser.sv
// tb_eth_rx_parser: scoreboard bench for eth_rx_parser with directed frames.
module tb_eth_rx_parser;
   localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
   localparam logic [47:0] SRC   = 48'h00_11_22_33_44_55;
   typedef struct packed {logic [7:0] d; logic l; logic e;} beat_t;
   typedef struct packed {
      logic [15:0] len, et;
      logic [47:0] dst, src;
      logic ce, ru, gi, fi;
   } stat_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
   logic [7:0]  out_data;
   logic        out_valid, out_last, out_err, out_ready = 1'b1;
   logic        stat_valid, stat_crc_err, stat_runt, stat_giant, stat_filtered;
   logic [15:0] stat_len, stat_ethertype;
   logic [47:0] stat_dst_mac, stat_src_mac;

   beat_t      exp_b[$];
   stat_t      exp_s[$];
   beat_t      mb, gb;
   stat_t      ms, gs;
   logic [7:0] frm [0:1599];
   int         frm_n;
   int         tests = 0, fails = 0, rcyc = 0;
   bit         mon_en = 1'b1, tog = 1'b0;

   eth_rx_parser dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_err(out_err),
      .out_ready(out_ready),
      .stat_valid(stat_valid), .stat_len(stat_len), .stat_ethertype(stat_ethertype),
      .stat_dst_mac(stat_dst_mac), .stat_src_mac(stat_src_mac),
      .stat_crc_err(stat_crc_err), .stat_runt(stat_runt), .stat_giant(stat_giant),
      .stat_filtered(stat_filtered)
   );

   always #5 clk = ~clk;

   // Downstream ready: constant 1, or the repeating 1-0-0-1 pattern.
   initial forever begin
      @(posedge clk);
      #1;
      rcyc++;
      out_ready = tog ? ((rcyc % 4) == 0 || (rcyc % 4) == 3) : 1'b1;
   end

   // Monitor: pops the scoreboard whenever a beat or a status pulse is presented.
   initial forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
         if (out_valid && out_ready) begin
            tests++;
            gb = '{d: out_data, l: out_last, e: out_err};
            if (exp_b.size() == 0) begin
               fails++;
               $display("FAIL beat_unexpected got data=%h last=%b err=%b", out_data, out_last, out_err);
            end else begin
               mb = exp_b.pop_front();
               if (gb !== mb) begin
                  fails++;
                  $display("FAIL beat got data=%h last=%b err=%b want data=%h last=%b err=%b",
                           gb.d, gb.l, gb.e, mb.d, mb.l, mb.e);
               end
            end
         end
         if (stat_valid) begin
            tests++;
            gs = '{len: stat_len, et: stat_ethertype, dst: stat_dst_mac, src: stat_src_mac,
                   ce: stat_crc_err, ru: stat_runt, gi: stat_giant, fi: stat_filtered};
            if (exp_s.size() == 0) begin
               fails++;
               $display("FAIL stat_unexpected got len=%0d", stat_len);
            end else begin
               ms = exp_s.pop_front();
               if (gs !== ms) begin
                  fails++;
                  $display("FAIL stat got len=%0d et=%h dst=%h src=%h ce/ru/gi/fi=%b%b%b%b want len=%0d et=%h dst=%h src=%h ce/ru/gi/fi=%b%b%b%b",
                           gs.len, gs.et, gs.dst, gs.src, gs.ce, gs.ru, gs.gi, gs.fi,
                           ms.len, ms.et, ms.dst, ms.src, ms.ce, ms.ru, ms.gi, ms.fi);
               end
            end
         end
      end
   end

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Header + incrementing payload, then a valid FCS over the first n-4 bytes.
   task automatic build(input int n, input logic [47:0] dst, input logic [7:0] seed);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      frm_n = n;
      for (int i = 0; i < n - 4; i++) begin
         frm[i] = (i < 6) ? dst[8*(5-i) +: 8] : (i < 12) ? SRC[8*(11-i) +: 8] :
                  (i == 12) ? 8'h08 : (i == 13) ? 8'h00 : 8'(i * 3) + seed;
         c = crc_step(c, frm[i]);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) frm[n-4+i] = c[8*i +: 8];
   endtask

   task automatic expect_frame(input int nb, input logic err, input logic ce, input logic ru,
                               input logic gi, input logic fi);
      for (int j = 0; j < nb; j++)
         exp_b.push_back('{d: frm[14+j], l: j == nb - 1, e: (j == nb - 1) && err});
      exp_s.push_back('{len: 16'(frm_n), et: {frm[12], frm[13]},
                        dst: {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]},
                        src: {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]},
                        ce: ce, ru: ru, gi: gi, fi: fi});
   endtask

   task automatic send(input int n);
      bit acc;
      int k;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = frm[i];
         in_last  = (i == frm_n - 1);
         k = 0;
         do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
         end while (!acc && k < 200);
         if (!acc) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout got 0 want 1 at byte %0d", i);
         end
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_b.size() != 0 || exp_s.size() != 0) && k < 5000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain_beats_left", 64'(exp_b.size()), 64'd0);
      chk("drain_stats_left", 64'(exp_s.size()), 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_stat_valid", 64'(stat_valid), 64'd0);
      chk("rst_stat_len", 64'(stat_len), 64'd0);
      chk("rst_stat_flags", 64'({stat_crc_err, stat_runt, stat_giant, stat_filtered}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // 64-byte good frame: 46 beats, clean status
      build(64, LOCAL, 8'h00); expect_frame(46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); send(64); idle(2);
      // payload bit flip: CRC error
      build(64, LOCAL, 8'h00); frm[20] = frm[20] ^ 8'h04;
      expect_frame(46, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); send(64); idle(2);
      // 40-byte runt: 22 beats, err on last
      build(40, LOCAL, 8'h11); expect_frame(22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); send(40); idle(2);
      // 16-byte frame: status only
      build(16, LOCAL, 8'h22); expect_frame(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); send(16); idle(2);
      // 19-byte frame: smallest with a beat
      build(19, LOCAL, 8'h33); expect_frame(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); send(19); idle(2);
      // 1600-byte giant: beats for bytes 14..1514, last/err on byte 1514
      build(1600, LOCAL, 8'h44); expect_frame(1501, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); send(1600); idle(2);
      drain();
      // back-to-back frames under 1-0-0-1 back-pressure
      tog = 1'b1;
      build(70, LOCAL, 8'h05); expect_frame(52, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); send(70);
      build(65, LOCAL, 8'h09); expect_frame(47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); send(65);
      idle(4);
      drain();
      tog = 1'b0;
`ifdef ETH_RX_DST_FILTER_EN
      build(64, 48'h02_00_00_00_00_02, 8'h55); expect_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); send(64); idle(2);
      build(64, 48'hFF_FF_FF_FF_FF_FF, 8'h66); expect_frame(46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); send(64); idle(2);
      drain();
`endif
      // reset mid-payload: nothing from the aborted frame, next frame clean
      mon_en = 1'b0;
      build(64, LOCAL, 8'h77); send(30);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_out_last", 64'(out_last), 64'd0);
      chk("abort_out_data", 64'(out_data), 64'd0);
      chk("abort_stat_valid", 64'(stat_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      build(64, LOCAL, 8'h03); expect_frame(46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); send(64); idle(4);
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/eth_rx_parser.md
# eth_rx_parser

Parametrised Ethernet frame receiver that replaces the fixed 1500-byte payload register with a streaming, back-pressured path. It accepts a byte stream from the MAC/PHY side with an end-of-frame marker, then captures the 14-byte header. It forwards only the payload downstream, with the 4-byte FCS stripped. It also checks CRC-32 and frame length, and reports a per-frame status word.

## Interface
- `MIN_FRAME`, 64: minimum legal frame length in bytes (header + payload + FCS).
- `MAX_FRAME`, 1518: maximum legal frame length in bytes.
- `LOCAL_MAC`, 48'h02_00_00_00_00_01: station address used by the destination filter.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: received byte. Byte 0 is the first destination-MAC byte.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: this byte is the final FCS byte.
- `in_ready` out 1: a byte is accepted when `in_valid && in_ready`.
- `out_data` out 8: payload byte.
- `out_valid` out 1: payload beat valid.
- `out_last` out 1: final payload beat.
- `out_err` out 1: qualifies `out_last`; set when the frame is bad.
- `out_ready` in 1: downstream accept.
- `stat_valid` out 1: one-cycle status pulse per frame.
- `stat_len` out 16: total frame bytes, saturating at 16'hFFFF.
- `stat_ethertype` out 16: bytes 12–13, big-endian.
- `stat_dst_mac`, `stat_src_mac` out 48 each: captured header addresses.
- `stat_crc_err`, `stat_runt`, `stat_giant`, `stat_filtered` out 1 each: status flags.

## Operation
- **Reset:** all outputs are 0, FSM is in IDLE, byte count is 0, CRC register is 32'hFFFF_FFFF, delay line is empty.
- **`in_ready`:** `in_ready = !out_valid || out_ready`. The delay line and counter advance only on accepted bytes.
- **FSM states:**
  - IDLE: first accepted byte → HDR.
  - HDR: byte count < 14. Capture destination MAC, source MAC and EtherType. At count 14 → PAYLOAD.
  - PAYLOAD: forward payload bytes.
  - DROP: consume bytes, forward nothing, until `in_last`.
  - Any state: accepted `in_last` → IDLE, and counter/CRC/delay line reset.
- **FCS stripping:** accepted bytes pass through a 4-entry delay line. When byte k is accepted, byte k−4 emerges. The emerging byte is forwarded only if k−4 ≥ 14 and the state is PAYLOAD. `out_last` is asserted with the byte emerging alongside `in_last`, which is byte N−5.
- **CRC:**
  - Reflected CRC-32: polynomial 0xEDB88320, initial value 0xFFFFFFFF, computed over every byte including the FCS.
  - The frame is good when the register equals 0xDEBB20E3 after the last byte.
- **Length checks:**
  - Runt when N < `MIN_FRAME`.
  - Giant when the count reaches `MAX_FRAME`+1. On that byte, emit the emerging beat with `out_last`=1 and `out_err`=1, then go to DROP.
- **`out_err` on `out_last`:** equals CRC error OR runt.
- **Short frames:** frames with N ≤ 18 produce no payload beats, only status.
- **Status:** `stat_*` are registered and pulse one cycle after the `in_last` acceptance.
- **Back-to-back frames:** a new frame's first byte may be accepted in the cycle after `in_last`.
- **Reset mid-frame:** everything is aborted. No `out_last` and no status are produced for the aborted frame.

## Timing
- Output latency: a payload byte appears on `out_*` the cycle after byte k+4 is accepted, and stays until `out_ready`.
- Status latency: 1 cycle after the `in_last` acceptance.
- Throughput: 1 byte per cycle with `out_ready` held high.
- `stat_valid` is not back-pressured.

## Configuration
- `ETH_RX_DST_FILTER_EN` defined:
  - After byte 5, if the destination is neither `LOCAL_MAC` nor FF:FF:FF:FF:FF:FF, go to DROP.
  - No payload beats are emitted for a dropped frame.
  - Status is still produced, with `stat_filtered`=1.
- `ETH_RX_DST_FILTER_EN` undefined: all frames are forwarded and `stat_filtered` is tied to 0.

## Structure
- Package `eth_pkg` holds:
  - `ETH_HDR_LEN`=14, `ETH_FCS_LEN`=4
  - `CRC32_POLY`, `CRC32_INIT`, `CRC32_RESIDUE`
  - `ETH_BCAST_MAC`
  - the FSM state enum
- Sub-module `eth_crc32` (ports: `clk`, `rst_n`, `clear`, `en`, `data[7:0]`, `crc[31:0]`) provides one byte per cycle, where `clear` reloads `CRC32_INIT`.

## Test plan
- 64-byte frame, correct FCS, `out_ready`=1 → 46 payload beats, `out_last` on beat 46, `out_err`=0; status shows `stat_len`=64 and all flags 0.
- Same frame with one payload bit flipped → `out_last` with `out_err`=1; `stat_crc_err`=1.
- 40-byte frame with valid FCS → 22 beats, `out_err`=1; `stat_runt`=1. A 16-byte frame → zero beats, status only.
- 1600-byte frame → `out_last` and `out_err` on the beat emitted when byte 1519 is accepted, no further beats; `stat_giant`=1, `stat_len`=1600.
- `out_ready` toggled 1-0-0-1 throughout, plus back-to-back frames with `in_last` followed immediately by the next byte 0 → payloads are byte-exact and 2 status pulses are produced.
- With `ETH_RX_DST_FILTER_EN`: destination 02:00:00:00:00:02 → no beats, `stat_filtered`=1. Broadcast destination → forwarded. Assert `rst_n` low mid-payload → outputs are 0, and the next frame parses cleanly.
